// File: rtl/loc_sram_pkg.sv
// Shared constants, FSM state encoding and lane-to-mask-bit mapping for the
// local SRAM scheduler (16 rows x 256 lanes x 5 bits).
package loc_sram_pkg;

    localparam int LOC_ADDR_SPACE = 4;
    localparam int LOC_BW         = 5;
    localparam int LOC_D          = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RSP,
        ST_CLR
    } sched_state_t;

    localparam logic GRANT_UPD = 1'b0;
    localparam logic GRANT_RD  = 1'b1;

    // vid 0 lives in the MSBs, so lane L maps to mask bit / slot D-1-L
    function automatic int keep_idx(input int d, input logic [7:0] lane);
        return d - 1 - int'(lane);
    endfunction

endpackage

// File: rtl/loc_sram_lane_wr.sv
// Single-lane write formatter: builds the keep mask (all ones except the
// addressed lane) and places the lane value into its slot of the row word.
module loc_sram_lane_wr
    import loc_sram_pkg::*;
#(
    parameter int BW = LOC_BW,
    parameter int D  = LOC_D
) (
    input  logic [7:0]      lane,
    input  logic [BW-1:0]   data,
    output logic [D-1:0]    keep_mask,
    output logic [D*BW-1:0] wdata
);

    always_comb begin
        keep_mask = '1;
        wdata     = '0;
        for (int i = 0; i < D; i++) begin
            if (i == keep_idx(D, lane)) begin
                keep_mask[i]       = 1'b0;
                wdata[i*BW +: BW]  = data;
            end
        end
    end

endmodule

// File: rtl/loc_sram_sched.sv
// Local SRAM scheduler: round-robin between single-lane updates and row reads,
// with optional read-and-clear built only when LOC_SRAM_CLR_EN is defined.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | arbitrate update vs. read; update writes issue from here
// ST_RD_ISSUE | sram_raddr holds the accepted row
// ST_RD_WAIT  | sram_rdata valid, captured into rsp_data at cycle end
// ST_RSP      | response held; rsp_valid rises one cycle after entry
// ST_CLR      | one-cycle row-clear write strobe (clear builds only)
module loc_sram_sched
    import loc_sram_pkg::*;
#(
    parameter int ADDR_SPACE = LOC_ADDR_SPACE,
    parameter int BW         = LOC_BW,
    parameter int D          = LOC_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_SPACE-1:0] upd_addr,
    input  logic [7:0]            upd_lane,
    input  logic [BW-1:0]         upd_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_SPACE-1:0] rd_addr,
    input  logic                  rd_clear,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [D*BW-1:0]       rsp_data,
    output logic                  sram_wsb,
    output logic [D-1:0]          sram_bytemask,
    output logic [D*BW-1:0]       sram_wdata,
    output logic [ADDR_SPACE-1:0] sram_waddr,
    output logic [ADDR_SPACE-1:0] sram_raddr,
    input  logic [D*BW-1:0]       sram_rdata
);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              last_grant;
    logic              hazard;
    logic              rd_req_ok;
    logic              upd_fire;
    logic              rd_fire;
    logic              rsp_fire;
    logic [D-1:0]      lane_mask;
    logic [D*BW-1:0]   lane_wdata;
`ifdef LOC_SRAM_CLR_EN
    logic              clear_q;
`else
    logic              unused_rd_clear;
    assign unused_rd_clear = rd_clear;
`endif

    // A read of the row currently being written waits one cycle for the write to land
    assign hazard    = !sram_wsb && (rd_addr == sram_waddr);
    assign rd_req_ok = rd_valid && !hazard;
    assign upd_fire  = upd_valid && upd_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    loc_sram_lane_wr #(
        .BW (BW),
        .D  (D)
    ) u_lane_wr (
        .lane      (upd_lane),
        .data      (upd_data),
        .keep_mask (lane_mask),
        .wdata     (lane_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (rd_fire) state_nxt = ST_RD_ISSUE;
            ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  state_nxt = ST_RSP;
            ST_RSP: begin
                if (rsp_fire) begin
`ifdef LOC_SRAM_CLR_EN
                    state_nxt = clear_q ? ST_CLR : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Ready depends on the other requester only when both compete for the grant
    always_comb begin
        upd_ready = 1'b0;
        rd_ready  = 1'b0;
        if (state == ST_IDLE && !rst) begin
            upd_ready = !(rd_req_ok && last_grant == GRANT_UPD);
            rd_ready  = !hazard && !(upd_valid && last_grant == GRANT_RD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant    <= GRANT_UPD;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            sram_wsb      <= 1'b1;
            sram_bytemask <= '1;
            sram_wdata    <= '0;
            sram_waddr    <= '0;
            sram_raddr    <= '0;
`ifdef LOC_SRAM_CLR_EN
            clear_q       <= 1'b0;
`endif
        end else begin
            rsp_valid <= (state == ST_RSP) && !rsp_fire;
            if (state == ST_RD_WAIT) begin
                rsp_data <= sram_rdata;
            end

            if (rd_fire) begin
                sram_raddr <= rd_addr;
                last_grant <= GRANT_RD;
`ifdef LOC_SRAM_CLR_EN
                clear_q    <= rd_clear;
`endif
            end else if (upd_fire) begin
                last_grant <= GRANT_UPD;
            end

            sram_wsb      <= 1'b1;
            sram_bytemask <= '1;
            sram_wdata    <= '0;
            if (upd_fire) begin
                sram_wsb      <= 1'b0;
                sram_waddr    <= upd_addr;
                sram_bytemask <= lane_mask;
                sram_wdata    <= lane_wdata;
            end
`ifdef LOC_SRAM_CLR_EN
            // Clear reuses the read address, which is held until the next accept
            if (rsp_fire && clear_q) begin
                sram_wsb      <= 1'b0;
                sram_waddr    <= sram_raddr;
                sram_bytemask <= '0;
                sram_wdata    <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_loc_sram_sched.sv
// Self-checking bench for loc_sram_sched with a behavioural SRAM macro and a
// response scoreboard; clear expectations follow LOC_SRAM_CLR_EN.
module tb_loc_sram_sched;

    localparam int AW = 4;
    localparam int BW = 5;
    localparam int D  = 256;
    localparam int W  = D * BW;
`ifdef LOC_SRAM_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_addr = '0;
    logic [7:0]    upd_lane = '0;
    logic [BW-1:0] upd_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_clear = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          sram_wsb;
    logic [D-1:0]  sram_bytemask;
    logic [W-1:0]  sram_wdata;
    logic [AW-1:0] sram_waddr;
    logic [AW-1:0] sram_raddr;
    logic [W-1:0]  sram_rdata = '0;

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] addr;
        logic          clr;
    } rsp_t;

    logic [W-1:0] mem     [16];
    logic [W-1:0] exp_mem [16];
    logic [W-1:0] row_tmp;
    rsp_t         exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    loc_sram_sched dut (
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_addr      (upd_addr),
        .upd_lane      (upd_lane),
        .upd_data      (upd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_clear      (rd_clear),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .sram_wsb      (sram_wsb),
        .sram_bytemask (sram_bytemask),
        .sram_wdata    (sram_wdata),
        .sram_waddr    (sram_waddr),
        .sram_raddr    (sram_raddr),
        .sram_rdata    (sram_rdata)
    );

    // SRAM macro: masked write at the edge, registered read of the sampled address
    always @(posedge clk) begin
        if (!sram_wsb) begin
            row_tmp = mem[sram_waddr];
            for (int i = 0; i < D; i++)
                if (!sram_bytemask[i]) row_tmp[i*BW +: BW] = sram_wdata[i*BW +: BW];
            mem[sram_waddr] <= row_tmp;
        end
        sram_rdata <= mem[sram_raddr];
    end

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int l = 0; l < D; l++)
            if (a[(D-1-l)*BW +: BW] !== b[(D-1-l)*BW +: BW]) return l;
        return 0;
    endfunction

    task automatic send_upd(input logic [AW-1:0] a, input logic [7:0] l, input logic [BW-1:0] d);
        bit ok = 1'b0;
        upd_valid = 1'b1; upd_addr = a; upd_lane = l; upd_data = d;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk); ok = upd_ready;
            @(posedge clk);
        end
        #1 upd_valid = 1'b0;
        if (ok) exp_mem[a][(D-1-int'(l))*BW +: BW] = d;
        else begin
            vectors++; miscompares++;
            $display("FAIL upd_timeout: upd_ready got 0 want 1 within 40 cycles");
        end
    endtask

    task automatic send_rd(input logic [AW-1:0] a, input logic clr);
        bit ok = 1'b0;
        rd_valid = 1'b1; rd_addr = a; rd_clear = clr;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk); ok = rd_ready;
            @(posedge clk);
        end
        if (ok) exp_q.push_back('{data: exp_mem[a], addr: a, clr: clr && CLR_EN});
        #1 rd_valid = 1'b0; rd_clear = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL rd_timeout: rd_ready got 0 want 1 within 40 cycles");
        end
    endtask

    task automatic get_rsp(output logic [W-1:0] got, output rsp_t e);
        int c = 0;
        while (!rsp_valid && c < 20) begin
            @(posedge clk); #1; c++;
        end
        if (!rsp_valid) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: rsp_valid got 0 want 1 within 20 cycles");
        end
        got = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        e = '{data: '0, addr: '0, clr: 1'b0};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.clr) exp_mem[e.addr] = '0;
        end else begin
            vectors++; miscompares++;
            $display("FAIL rsp_unexpected: queue depth got 0 want >0");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; upd_valid = 1'b1; rd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({upd_ready, rd_ready, rsp_valid, sram_wsb} !== 4'b0001) begin miscompares++;
            $display("FAIL rst_ctrl: got %b want 0001", {upd_ready, rd_ready, rsp_valid, sram_wsb}); end
        vectors++; if (sram_bytemask !== {D{1'b1}}) begin miscompares++;
            $display("FAIL rst_mask: got %h want all ones", sram_bytemask); end
        vectors++; if (rsp_data !== '0) begin miscompares++;
            $display("FAIL rst_rsp_data: got nonzero want 0"); end
        vectors++; if (sram_wdata !== '0) begin miscompares++;
            $display("FAIL rst_wdata: got nonzero want 0"); end
        vectors++; if ({sram_waddr, sram_raddr} !== '0) begin miscompares++;
            $display("FAIL rst_addr: got %h want 0", {sram_waddr, sram_raddr}); end
        upd_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_update_write();
        logic [D-1:0] em;
        logic [W-1:0] ew;
        send_upd(4'd3, 8'd0, 5'h1F);
        em = '1; em[D-1] = 1'b0;
        ew = '0; ew[W-1 -: BW] = 5'h1F;
        vectors++; if ({sram_wsb, sram_waddr} !== {1'b0, 4'd3}) begin miscompares++;
            $display("FAIL upd_strobe: got wsb=%b waddr=%0d want wsb=0 waddr=3", sram_wsb, sram_waddr); end
        vectors++; if (sram_bytemask !== em) begin miscompares++;
            $display("FAIL upd_mask: got %h want %h", sram_bytemask, em); end
        vectors++; if (sram_wdata !== ew) begin miscompares++;
            $display("FAIL upd_wdata: got lane0 %h want %h (or stray bits)", sram_wdata[W-1 -: BW], 5'h1F); end
        @(posedge clk); #1;
        vectors++; if ({sram_wsb, sram_bytemask} !== {1'b1, {D{1'b1}}}) begin miscompares++;
            $display("FAIL upd_idle_drive: got wsb=%b want wsb=1 mask all ones", sram_wsb); end
        send_upd(4'd3, 8'd255, 5'h0A);
        em = '1; em[0] = 1'b0;
        vectors++; if ({sram_bytemask, sram_wdata[BW-1:0]} !== {em, 5'h0A}) begin miscompares++;
            $display("FAIL upd_lane255: got mask0=%b data=%h want 0 0a", sram_bytemask[0], sram_wdata[BW-1:0]); end
    endtask

    task automatic test_read_clear();
        logic [W-1:0] got;
        rsp_t e;
        int k = 0;
        send_rd(4'd3, 1'b1);
        while (!rsp_valid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        vectors++; if (k != 3) begin miscompares++;
            $display("FAIL rd_latency: got %0d edges want 3", k); end
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL rd_data lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
        vectors++; if (got[W-1 -: BW] !== 5'h1F) begin miscompares++;
            $display("FAIL rd_lane0: got %h want 1f", got[W-1 -: BW]); end
`ifdef LOC_SRAM_CLR_EN
        vectors++; if ({sram_wsb, sram_waddr, sram_bytemask, sram_wdata} !== {1'b0, 4'd3, {D{1'b0}}, {W{1'b0}}}) begin miscompares++;
            $display("FAIL clr_write: got wsb=%b waddr=%0d mask_or=%b data_or=%b want 0 3 0 0",
                     sram_wsb, sram_waddr, |sram_bytemask, |sram_wdata); end
`else
        vectors++; if (sram_wsb !== 1'b1) begin miscompares++;
            $display("FAIL no_clr_write: got wsb=%b want 1", sram_wsb); end
`endif
        send_rd(4'd3, 1'b0);
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL reread lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
`ifdef LOC_SRAM_CLR_EN
        vectors++; if (got !== '0) begin miscompares++;
            $display("FAIL reread_zero: got nonzero row want 0"); end
`endif
    endtask

    task automatic test_arbitration();
        logic [W-1:0] got;
        rsp_t e;
        send_upd(4'd6, 8'd10, 5'h07);
        upd_valid = 1'b1; upd_addr = 4'd6; upd_lane = 8'd11; upd_data = 5'h09;
        rd_valid = 1'b1; rd_addr = 4'd10; rd_clear = 1'b0;
        @(negedge clk);
        vectors++; if ({rd_ready, upd_ready} !== 2'b10) begin miscompares++;
            $display("FAIL arb_rr: got rd_ready=%b upd_ready=%b want 1 0", rd_ready, upd_ready); end
        @(posedge clk);
        exp_q.push_back('{data: exp_mem[10], addr: 4'd10, clr: 1'b0});
        #1 rd_valid = 1'b0;
        @(negedge clk);
        vectors++; if (upd_ready !== 1'b0) begin miscompares++;
            $display("FAIL arb_busy: upd_ready got %b want 0", upd_ready); end
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL arb_rd lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
        vectors++; if (upd_ready !== 1'b1) begin miscompares++;
            $display("FAIL arb_upd_after: upd_ready got %b want 1", upd_ready); end
        @(posedge clk);
        exp_mem[6][(D-1-11)*BW +: BW] = 5'h09;
        #1 upd_valid = 1'b0;
        send_rd(4'd6, 1'b0);
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL arb_row6 lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
    endtask

    task automatic test_hazard();
        logic [W-1:0] got;
        rsp_t e;
        send_upd(4'd5, 8'd200, 5'h15);
        rd_valid = 1'b1; rd_addr = 4'd5; rd_clear = 1'b0;
        @(negedge clk);
        vectors++; if (rd_ready !== 1'b0) begin miscompares++;
            $display("FAIL raw_block: rd_ready got %b want 0", rd_ready); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (rd_ready !== 1'b1) begin miscompares++;
            $display("FAIL raw_release: rd_ready got %b want 1", rd_ready); end
        @(posedge clk);
        exp_q.push_back('{data: exp_mem[5], addr: 4'd5, clr: 1'b0});
        #1 rd_valid = 1'b0;
        get_rsp(got, e);
        vectors++; if (got[(D-1-200)*BW +: BW] !== 5'h15) begin miscompares++;
            $display("FAIL raw_lane200: got %h want 15", got[(D-1-200)*BW +: BW]); end
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL raw_row lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
    endtask

    task automatic test_rsp_stall();
        logic [W-1:0] got;
        rsp_t e;
        int c = 0;
        send_rd(4'd9, 1'b0);
        while (!rsp_valid && c < 10) begin
            @(negedge clk); c++;
        end
        upd_valid = 1'b1; upd_addr = 4'd12; upd_lane = 8'd3; upd_data = 5'h11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++; if ({rsp_valid, upd_ready, sram_wsb} !== 3'b101) begin miscompares++;
                $display("FAIL stall_ctrl cyc %0d: got valid/upd_ready/wsb=%b want 101", i, {rsp_valid, upd_ready, sram_wsb}); end
            vectors++; if (exp_q.size() == 0 || rsp_data !== exp_q[0].data) begin miscompares++;
                $display("FAIL stall_data cyc %0d: got lane0 %h want held row of addr 9", i, rsp_data[W-1 -: BW]); end
        end
        upd_valid = 1'b0;
        @(posedge clk); #1;
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL stall_rsp lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
        send_upd(4'd12, 8'd3, 5'h11);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        rsp_t e;
        upd_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            upd_addr = 4'd8; upd_lane = 8'(j * 60 + 1); upd_data = 5'(j + 20);
            @(negedge clk);
            vectors++; if (upd_ready !== 1'b1) begin miscompares++;
                $display("FAIL b2b_ready %0d: got %b want 1", j, upd_ready); end
            @(posedge clk);
            exp_mem[8][(D-1-(j*60+1))*BW +: BW] = 5'(j + 20);
            #1;
            vectors++; if ({sram_wsb, sram_waddr} !== {1'b0, 4'd8}) begin miscompares++;
                $display("FAIL b2b_strobe %0d: got wsb=%b waddr=%0d want 0 8", j, sram_wsb, sram_waddr); end
        end
        upd_valid = 1'b0;
        send_rd(4'd8, 1'b0);
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL b2b_row lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] got;
        rsp_t e;
        send_rd(4'd7, 1'b1);
        rst = 1'b1;
        #1;
        vectors++; if ({rsp_valid, rd_ready, sram_wsb, sram_raddr} !== {3'b001, 4'd0}) begin miscompares++;
            $display("FAIL midrst_out: got valid/rdy/wsb=%b raddr=%0d want 001 0", {rsp_valid, rd_ready, sram_wsb}, sram_raddr); end
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if ({rsp_valid, sram_wsb} !== 2'b01) begin miscompares++;
                $display("FAIL midrst_quiet %0d: got valid/wsb=%b want 01", i, {rsp_valid, sram_wsb}); end
        end
        @(posedge clk); #1;
        send_rd(4'd7, 1'b0);
        get_rsp(got, e);
        vectors++; if (got !== e.data) begin miscompares++;
            $display("FAIL midrst_reread lane %0d: got %h want %h", first_diff(got, e.data),
                     got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
    endtask

    task automatic test_random();
        logic [W-1:0] got;
        rsp_t e;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                send_upd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)));
            end else begin
                send_rd(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                get_rsp(got, e);
                vectors++; if (got !== e.data) begin miscompares++;
                    $display("FAIL rand_rd %0d lane %0d: got %h want %h", n, first_diff(got, e.data),
                             got[(D-1-first_diff(got, e.data))*BW +: BW], e.data[(D-1-first_diff(got, e.data))*BW +: BW]); end
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < D; i++) begin
                mem[r][i*BW +: BW]     = 5'(((r * 37 + i * 11) % 31) + 1);
                exp_mem[r][i*BW +: BW] = 5'(((r * 37 + i * 11) % 31) + 1);
            end
        end
        test_reset();
        test_update_write();
        test_read_clear();
        test_arbitration();
        test_hazard();
        test_rsp_stall();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
